// File: rtl/sensor_frame_uart_tx.sv
// sensor_frame_uart_tx: captures the 16-byte sensor image streamed by the RAM
// scanner and, once per frame period, sends the latest complete image as a
// 19-byte UART 8N1 packet (0x55, 0xAA, 16 payload bytes, 8-bit checksum).
module sensor_frame_uart_tx #(
  parameter int unsigned CLK_DIV      = 868,
  parameter int unsigned FRAME_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  input  logic       ram_wen,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_PERIOD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [4:0] BI_LAST   = 5'd18;
  localparam logic [7:0] HDR_BYTE0 = 8'h55;
  localparam logic [7:0] HDR_BYTE1 = 8'hAA;

  // Capture state
  logic [3:0]       exp_q, exp_d;
  logic [15:0][7:0] cap_q, cap_d;
  logic [15:0][7:0] snap_q, snap_d;
  logic             snap_valid_q, snap_valid_d;

  // Frame-rate tick
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;

  // Transmitter state
  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [4:0]       bi_q, bi_d;
  logic [7:0]       sum_q, sum_d;
  logic [15:0][7:0] txbuf_q, txbuf_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             addr_hit;
  logic             baud_end;
  logic             is_payload;
  logic [3:0]       pidx;
  logic [7:0]       cur_byte;

  // Sequence-checked capture; the snapshot copy includes the byte being written at index 15
  always_comb begin
    exp_d        = exp_q;
    cap_d        = cap_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    addr_hit     = ram_wen && (ram_addr == {4'h0, exp_q});
    if (addr_hit) begin
      cap_d[exp_q] = ram_data;
      if (exp_q == 4'hF) begin
        exp_d        = '0;
        snap_d       = cap_q;
        snap_d[15]   = ram_data;
        snap_valid_d = 1'b1;
      end else begin
        exp_d = exp_q + 4'd1;
      end
    end else if (ram_wen && (ram_addr == 8'h00)) begin
      cap_d[0] = ram_data;
      exp_d    = 4'd1;
    end else if (ram_wen) begin
      exp_d = '0;
    end
  end

  // Capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q        <= '0;
      cap_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      exp_q        <= exp_d;
      cap_q        <= cap_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Free-running frame-rate counter; tick marks the wrap cycle
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Byte selection for the current frame position
  always_comb begin
    pidx       = bi_q[3:0] - 4'd2;
    is_payload = (bi_q >= 5'd2) && (bi_q <= 5'd17);
    case (bi_q)
      5'd0:    cur_byte = HDR_BYTE0;
      5'd1:    cur_byte = HDR_BYTE1;
      BI_LAST: cur_byte = sum_q;
      default: cur_byte = txbuf_q[pidx];
    endcase
  end

  // UART framing FSM; tx/busy are computed one cycle ahead so the outputs are registered
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bi_d        = bi_q;
    sum_d       = sum_q;
    txbuf_d     = txbuf_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    baud_end    = (baud_cnt_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick && snap_valid_q) begin
          state_d    = S_START;
          txbuf_d    = snap_q;
          bi_d       = '0;
          sum_d      = '0;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          shreg_d   = cur_byte;
          tx_d      = cur_byte[0];
          bit_cnt_d = '0;
          if (is_payload) begin
            sum_d = sum_q + cur_byte;
          end
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bi_q == BI_LAST) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            bi_d    = bi_q + 5'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick counter and transmitter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      bi_q        <= '0;
      sum_q       <= '0;
      txbuf_q     <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bi_q        <= bi_d;
      sum_q       <= sum_d;
      txbuf_q     <= txbuf_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sensor_frame_uart_tx.sv
// tb_sensor_frame_uart_tx: directed scans of the sensor image; expected UART
// bytes go into a scoreboard queue and a UART receiver process checks them.
module tb_sensor_frame_uart_tx;

  localparam int CLK_T = 10;
  localparam int CDIV  = 4;
  localparam int FPER  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ram_addr = '0;
  logic [7:0] ram_data = '0;
  logic       ram_wen = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] frame_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];

  sensor_frame_uart_tx #(.CLK_DIV(CDIV), .FRAME_PERIOD(FPER)) dut (
    .clk       (clk),
    .rst       (rst),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wen   (ram_wen),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #(CLK_T/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: samples every cycle of each bit on the falling edge
  task automatic rx_byte();
    logic [9:0] bits;
    logic       stable;
    logic       aborted;
    logic       v;
    bits = '0;
    stable = 1'b1;
    aborted = 1'b0;
    v = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CDIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst) aborted = 1'b1;
        if (c == 0) begin
          v = tx;
          bits[b] = tx;
        end else if (tx !== v) begin
          stable = 1'b0;
        end
      end
    end
    if (!aborted) begin
      check("uart_framing{stable,start,stop}", {29'd0, stable, bits[0], bits[9]}, 32'b101);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%02h expected no byte", bits[8:1]);
      end else begin
        check("uart_byte", {24'd0, bits[8:1]}, {24'd0, sb.pop_front()});
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) rx_byte();
    end
  end

  initial begin
    #(CLK_T * 60000);
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_frame(input logic [7:0] base, input logic [7:0] step, input logic [7:0] csum);
    sb.push_back(8'h55);
    sb.push_back(8'hAA);
    for (int i = 0; i < 16; i++) sb.push_back(base + step * 8'(i));
    sb.push_back(csum);
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    ram_addr = a;
    ram_data = d;
    ram_wen  = w;
  endtask

  task automatic scan(input logic [7:0] base, input logic [7:0] step, input logic w);
    for (int i = 0; i < 16; i++) write_byte(8'(i), base + step * 8'(i), w);
    @(negedge clk);
    ram_wen = 1'b0;
  endtask

  // Reset is checked one clock after it is sampled; leftover expectations are dropped
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ram_wen = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic wait_rise(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_rise_timeout: no frame within %0d clocks, expected one", limit);
    end
  endtask

  task automatic wait_fall(input int limit, input int exp_cnt, output int len);
    bit done;
    done = 1'b0;
    len = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        done = 1'b1;
        break;
      end
      len++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_fall_timeout: busy still high after %0d clocks, expected low", limit);
    end
    check("frame_cnt_at_fall", {24'd0, frame_cnt}, exp_cnt);
  endtask

  task automatic wait_frame(input int rise_limit, input int exp_cnt);
    bit ok;
    int len;
    wait_rise(rise_limit, ok);
    if (ok) begin
      wait_fall(1000, exp_cnt, len);
      check("busy_len", len + 1, 19 * 10 * CDIV);
    end
  endtask

  task automatic expect_no_frame(input int cycles);
    int hi;
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) hi++;
    end
    check("no_frame_active_cycles", hi, 0);
  endtask

  initial begin
    bit ok;
    int len;

    // Idle after reset: line stays high for three frame periods
    do_reset();
    expect_no_frame(3000);
    check("idle_frame_cnt", {24'd0, frame_cnt}, 32'd0);

    // Basic frame: payload 0x10..0x1F, checksum 0x78
    do_reset();
    scan(8'h10, 8'h01, 1'b1);
    push_frame(8'h10, 8'h01, 8'h78);
    wait_frame(1100, 1);
    check("sb_empty_basic", sb.size(), 0);

    // Broken sequence, then resync at addr 0, then a full run of 0xFF (checksum 0xF0)
    do_reset();
    for (int i = 0; i < 8; i++) write_byte(8'(i), 8'hFF, 1'b1);
    for (int i = 9; i < 16; i++) write_byte(8'(i), 8'hFF, 1'b1);
    write_byte(8'h20, 8'hFF, 1'b1);
    write_byte(8'h00, 8'h00, 1'b0);
    expect_no_frame(1100);
    for (int i = 0; i < 5; i++) write_byte(8'(i), 8'hFF, 1'b1);
    scan(8'hFF, 8'h00, 1'b1);
    push_frame(8'hFF, 8'h00, 8'hF0);
    wait_frame(1100, 1);
    check("sb_empty_resync", sb.size(), 0);

    // New snapshot mid-frame: in-flight frame unchanged, next frame carries 0x01s (checksum 0x10)
    do_reset();
    scan(8'h10, 8'h01, 1'b1);
    push_frame(8'h10, 8'h01, 8'h78);
    wait_rise(1100, ok);
    scan(8'h01, 8'h00, 1'b1);
    push_frame(8'h01, 8'h00, 8'h10);
    wait_fall(800, 1, len);
    wait_frame(300, 2);
    check("sb_empty_midframe", sb.size(), 0);

    // Scan with wen low never validates a snapshot; with wen high it does (checksum 0xF8)
    do_reset();
    scan(8'h00, 8'h11, 1'b0);
    expect_no_frame(1100);
    scan(8'h00, 8'h11, 1'b1);
    push_frame(8'h00, 8'h11, 8'hF8);
    wait_frame(1100, 1);
    check("sb_empty_wen", sb.size(), 0);

    // Reset during byte 7, then a fresh scan of 0x21..0x30 (checksum 0x88)
    do_reset();
    scan(8'h10, 8'h01, 1'b1);
    push_frame(8'h10, 8'h01, 8'h78);
    wait_rise(1100, ok);
    repeat (7 * 10 * CDIV + 15) @(negedge clk);
    check("sb_left_before_rst", sb.size(), 12);
    do_reset();
    scan(8'h21, 8'h01, 1'b1);
    push_frame(8'h21, 8'h01, 8'h88);
    wait_frame(1100, 1);
    check("sb_empty_after_rst", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_frame_uart_tx.md
# sensor_frame_uart_tx

Downstream consumer of the sensor RAM scanner. It captures the 16-byte sensor image (temperature, gyro X/Y/Z, mag X/Y/Z, two pad bytes) as the scanner cycles addresses 0..15. At a fixed frame rate it serialises the latest complete image as a framed, checksummed UART 8N1 packet toward the host.

## Interface
- CLK_DIV, default 868: clocks per UART bit (100 MHz / 115200); legal range ≥ 2.
- FRAME_PERIOD, default 1_000_000: clocks between frame-rate ticks (100 Hz); must be ≥ 190*CLK_DIV for no dropped ticks.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ram_addr  in  8  scanner address (byte index of the image).
- ram_data  in  8  scanner byte at ram_addr, valid the same cycle.
- ram_wen  in  1  byte-valid qualifier; byte is ignored when 0.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from the first start bit to the end of the last stop bit of a frame.
- frame_cnt  out  8  count of frames fully sent, wraps 255→0.

## Operation
- Capture, sequence-checked:
  - Counter exp (0..15, reset 0).
  - On each cycle with ram_wen=1 and ram_addr==exp: cap[exp] <= ram_data and exp increments.
  - When the byte stored is index 15: exp <= 0, copy cap[0..15] into snap[0..15] (the copy includes the index-15 byte being written), and set snap_valid=1. snap_valid is never cleared except by reset.
  - ram_wen=1, ram_addr≠exp, ram_addr==0: store as index 0 and set exp=1 (resync).
  - ram_wen=1, ram_addr≠exp, ram_addr≠0: exp <= 0, byte discarded.
  - ram_addr ≥ 16: treated as a mismatch.
- Tick: a free-running counter 0..FRAME_PERIOD-1 asserts tick for one cycle when it wraps to 0. The first tick is at cycle FRAME_PERIOD-1 after reset release.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on tick with snap_valid=1, latch snap into txbuf, set byte index bi=0 and sum=0, go to START.
  - Tick in a non-IDLE state, or with snap_valid=0: ignored.
  - START: tx=0 for CLK_DIV clocks, then go to DATA.
  - DATA: 8 bits, LSB first, CLK_DIV clocks each, then go to STOP.
  - STOP: tx=1 for CLK_DIV clocks. Then, if bi<18: bi++ and go to START. If bi==18: frame_cnt++ and go to IDLE.
- Frame byte sequence, 19 bytes:
  - bi 0: 0x55
  - bi 1: 0xAA
  - bi 2..17: txbuf[0..15]
  - bi 18: checksum = sum of txbuf[0..15] mod 256. Header bytes are excluded.
- sum accumulates each payload byte as it is loaded for sending. 8-bit wrap-around addition, no carry kept.
- Capture continues during transmission. Updating snap mid-frame does not affect txbuf; the next frame carries the newest snapshot.

## Timing
- Reset values: tx=1, busy=0, frame_cnt=0, snap_valid=0, exp=0, FSM=IDLE, tick counter=0, baud counter=0.
- Reset mid-frame: tx=1 and busy=0 in the cycle after rst is sampled high, and the frame is abandoned. frame_cnt is reset to 0. No partial byte is resumed after release.
- tx and busy are registered. The start bit appears (tx=0, busy=1) in the cycle after the tick cycle.
- Each bit lasts exactly CLK_DIV clocks. A byte is 10*CLK_DIV clocks; a frame is 190*CLK_DIV clocks.
- Bytes are sent back-to-back with no idle gap between a stop bit and the next start bit.
- busy falls, and frame_cnt increments, in the same cycle: the one after the last stop-bit clock.
- If a tick coincides with the final STOP cycle, it is ignored. The FSM is not yet IDLE, so that tick is dropped.
- If the capture of index 15 coincides with a tick, snap_valid becomes 1 only after that tick is evaluated. snap_valid is 0 on the first such event, so no frame starts that tick.
- Capture latency: from the index-15 byte to snap update is 1 clock.

## Test plan
- All tests use CLK_DIV=4 and FRAME_PERIOD=1000.
- Reset, then no ram_wen for 3000 clocks → tx stays 1, busy=0, frame_cnt=0.
- Scan addr 0..15 with data 0x10..0x1F and wen=1, then wait for a tick → decoded bytes are 55 AA 10 11 … 1F 78. Each bit is 4 clocks, busy is high for 760 clocks, frame_cnt=1.
- Scan 0..7, then jump to addr 9, then run a full 0..15 scan of 0xFF → the frame payload is all FF and the checksum is 0xF0. No frame is sent before the full run completes.
- Scan with data 0x01 while a frame of 0x10..0x1F is in flight → the in-flight frame is unchanged. The next frame's payload is all 01 and its checksum is 0x10.
- Scan with wen=0 on every byte → snap_valid stays 0 and no frame is sent. Repeat with wen=1 → a frame is sent.
- Assert rst at byte 7 of a frame → tx=1 and busy=0 on the next clock, frame_cnt=0. After release, a fresh full scan plus a tick produces a complete, correct frame.
